// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared state encoding and sizing constants for the memory sequencer
package mem_seq_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;
    localparam int NUM_REQ    = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_LD_MEM = 3'd2,
        ST_LD_CAP = 3'd3,
        ST_ST_DAT = 3'd4,
        ST_ST_WR  = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

endpackage

// File: rtl/mem_seq_arbiter_rr_arb2.sv
// rtl/mem_seq_arbiter_rr_arb2.sv - two-way round-robin arbiter with a last-grant register
module rr_arb2
    import mem_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    // 0 = port 0 won last, 1 = port 1 won last; reset to 1 so port 0 wins the first tie
    logic last_grant_q;
    logic last_grant_d;

    // Grant a lone requester outright; on a tie grant the port that did not win last time
    always_comb begin
        gnt_o = '0;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_grant_q ? 2'b01 : 2'b10;
            default: gnt_o = '0;
        endcase
    end

    // Only move the round-robin pointer when the grant is actually taken
    always_comb begin
        last_grant_d = last_grant_q;
        if (advance_i && (gnt_o != '0)) begin
            last_grant_d = gnt_o[1];
        end
    end

    // Last-grant register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_seq_arbiter.sv
// rtl/mem_seq_arbiter.sv - sequences MAR/MDR/memory load and store transactions for two requesters
module mem_seq_arbiter
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] bus_out,
    output logic              mar_en,
    output logic              mdr_en,
    output logic              mdr_from_mem,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mdr_q,
    output logic              busy
);

    state_e state_q, state_d;

    // Transaction fields captured at the grant edge; later input changes are ignored
    logic              sel_q, sel_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Registered datapath strobes, decoded from the state being entered
    logic              mar_en_q, mar_en_d;
    logic              mdr_en_q, mdr_en_d;
    logic              mdr_from_mem_q, mdr_from_mem_d;
    logic              mem_write_q, mem_write_d;
    logic [DATA_W-1:0] bus_out_q, bus_out_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] arb_gnt;
    logic               idle;

    assign idle = (state_q == ST_IDLE);

    // Requests are only visible to the arbiter while idle and out of reset
    always_comb begin
        arb_req = '0;
        if (idle && reset_n) begin
            arb_req = {req1, req0};
        end
    end

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (reset_n),
        .req_i     (arb_req),
        .advance_i (idle),
        .gnt_o     (arb_gnt)
    );

    // Next-state and transaction-capture logic
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_gnt != '0) begin
                    sel_d   = arb_gnt[1];
                    we_d    = arb_gnt[1] ? we1    : we0;
                    addr_d  = arb_gnt[1] ? addr1  : addr0;
                    wdata_d = arb_gnt[1] ? wdata1 : wdata0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR:   state_d = we_q ? ST_ST_DAT : ST_LD_MEM;
            ST_LD_MEM: state_d = ST_LD_CAP;
            ST_LD_CAP: begin
                rdata_d = mdr_q;
                state_d = ST_DONE;
            end
            ST_ST_DAT: state_d = ST_ST_WR;
            ST_ST_WR:  state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Decode strobes for the upcoming state so they appear as flop outputs in that state
    always_comb begin
        mar_en_d       = 1'b0;
        mdr_en_d       = 1'b0;
        mdr_from_mem_d = 1'b0;
        mem_write_d    = 1'b0;
        bus_out_d      = '0;
        done0_d        = 1'b0;
        done1_d        = 1'b0;
        case (state_d)
            ST_ADDR: begin
                mar_en_d  = 1'b1;
                bus_out_d = DATA_W'(addr_d);
            end
            ST_LD_MEM: begin
                mdr_en_d       = 1'b1;
                mdr_from_mem_d = 1'b1;
            end
            ST_ST_DAT: begin
                mdr_en_d  = 1'b1;
                bus_out_d = wdata_d;
            end
            ST_ST_WR:  mem_write_d = 1'b1;
            ST_DONE: begin
                done0_d = ~sel_d;
                done1_d = sel_d;
            end
            default: ;
        endcase
    end

    // State, captured fields and output registers; reset drops every strobe at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            sel_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            mar_en_q       <= 1'b0;
            mdr_en_q       <= 1'b0;
            mdr_from_mem_q <= 1'b0;
            mem_write_q    <= 1'b0;
            bus_out_q      <= '0;
            done0_q        <= 1'b0;
            done1_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rdata_q        <= rdata_d;
            mar_en_q       <= mar_en_d;
            mdr_en_q       <= mdr_en_d;
            mdr_from_mem_q <= mdr_from_mem_d;
            mem_write_q    <= mem_write_d;
            bus_out_q      <= bus_out_d;
            done0_q        <= done0_d;
            done1_q        <= done1_d;
        end
    end

    assign gnt0         = arb_gnt[0];
    assign gnt1         = arb_gnt[1];
    assign done0        = done0_q;
    assign done1        = done1_q;
    assign rdata        = rdata_q;
    assign bus_out      = bus_out_q;
    assign mar_en       = mar_en_q;
    assign mdr_en       = mdr_en_q;
    assign mdr_from_mem = mdr_from_mem_q;
    assign mem_write    = mem_write_q;
    assign busy         = !idle;

endmodule

// File: tb/tb_mem_seq_arbiter.sv
// tb/tb_mem_seq_arbiter.sv - self-checking bench for mem_seq_arbiter
`timescale 1ns/1ps
module tb_mem_seq_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, done0, done1, mar_en, mdr_en, mdr_from_mem, mem_write, busy;
    logic [DW-1:0] rdata, bus_out, mdr_q;
    logic [AW-1:0] mar_q;
    logic [DW-1:0] mem [0:511];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_seq_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .bus_out(bus_out), .mar_en(mar_en), .mdr_en(mdr_en),
        .mdr_from_mem(mdr_from_mem), .mem_write(mem_write), .mdr_q(mdr_q), .busy(busy)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 9'h054) return 32'h0000_0097;
        if (a == 9'h034) return 32'h0000_0025;
        return 32'hC0DE_0000 | DW'(a);
    endfunction

    // MAR / MDR / memory cluster driven by the sequencer strobes
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_val(AW'(i));
            mar_q <= '0;
            mdr_q <= '0;
        end else begin
            if (mar_en)    mar_q <= bus_out[AW-1:0];
            if (mdr_en)    mdr_q <= mdr_from_mem ? mem[mar_q] : bus_out;
            if (mem_write) mem[mar_q] <= mdr_q;
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] strb();
        return DW'({mar_en, mdr_en, mdr_from_mem, mem_write});
    endfunction

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    exp_gnt;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    // Runs one transaction from an idle negedge to the idle negedge after its done pulse
    task automatic run_vec(input vec_t v, input int idx);
        if (v.port) begin
            req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
        end else begin
            req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
        end
        #1;
        chk($sformatf("v%0d_gnt", idx), DW'({gnt1, gnt0}), DW'(v.exp_gnt));
        @(negedge clk);
        chk($sformatf("v%0d_addr_strb", idx), strb(), 32'h8);
        chk($sformatf("v%0d_addr_bus", idx), bus_out, DW'(v.addr));
        chk($sformatf("v%0d_gnt_pulse", idx), DW'({gnt1, gnt0}), 32'h0);
        addr0 = ~v.addr; addr1 = ~v.addr; wdata0 = ~v.wdata; wdata1 = ~v.wdata;
        we0 = ~v.we; we1 = ~v.we;
        @(negedge clk);
        chk($sformatf("v%0d_ph2_strb", idx), strb(), v.we ? 32'h4 : 32'h6);
        chk($sformatf("v%0d_ph2_bus", idx), bus_out, v.we ? v.wdata : 32'h0);
        @(negedge clk);
        chk($sformatf("v%0d_ph3_strb", idx), strb(), v.we ? 32'h1 : 32'h0);
        @(negedge clk);
        chk($sformatf("v%0d_done", idx), DW'({done1, done0}), DW'(v.exp_gnt));
        chk($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
        chk($sformatf("v%0d_done_strb", idx), strb(), 32'h0);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_idle", idx), DW'({busy, done1, done0}), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    exp_g [3];
        logic [1:0]    ghist [4];
        logic [DW-1:0] shadow [8];
        logic [DW-1:0] last_rd;
        logic          pend0, pend1;
        int            done_cnt, cyc;

        vecs[0] = '{1'b0, 1'b0, 9'h054, 32'h0,        2'b01, 32'h0000_0097};
        vecs[1] = '{1'b0, 1'b1, 9'h034, 32'h80,       2'b01, 32'h0000_0097};
        vecs[2] = '{1'b0, 1'b0, 9'h034, 32'h0,        2'b01, 32'h0000_0080};
        vecs[3] = '{1'b0, 1'b0, 9'h000, 32'h0,        2'b01, 32'hC0DE_0000};
        vecs[4] = '{1'b1, 1'b0, 9'h1FF, 32'h0,        2'b10, 32'hC0DE_01FF};
        vecs[5] = '{1'b1, 1'b1, 9'h100, 32'hCAFEF00D, 2'b10, 32'hC0DE_01FF};
        vecs[6] = '{1'b1, 1'b0, 9'h100, 32'h0,        2'b10, 32'hCAFE_F00D};

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_strb", strb(), 32'h0);
        chk("rst_flags", DW'({busy, gnt1, gnt0, done1, done0}), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_bus", bus_out, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // contention: last winner was port 1, so grants go 0,1,0
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 9'h010; addr1 = 9'h020;
        for (int t = 0; t < 3; t++) begin
            #1;
            chk($sformatf("cont%0d_gnt", t), DW'({gnt1, gnt0}), DW'(exp_g[t]));
            repeat (4) @(negedge clk);
            chk($sformatf("cont%0d_done", t), DW'({done1, done0}), DW'(exp_g[t]));
            chk($sformatf("cont%0d_rdata", t), rdata, exp_g[t][0] ? 32'hC0DE_0010 : 32'hC0DE_0020);
            if (t == 2) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            @(negedge clk);
        end
        #1;
        chk("cont_end_idle", DW'({busy, gnt1, gnt0}), 32'h0);

        // request withdrawal after grant, with port 0 waiting
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0; addr1 = 9'h054;
        #1;
        chk("wd_gnt1", DW'({gnt1, gnt0}), 32'h2);
        @(negedge clk);
        req1 = 1'b0; addr1 = 9'h1FF; req0 = 1'b1; we0 = 1'b0; addr0 = 9'h034;
        #1;
        chk("wd_bus_orig", bus_out, 32'h054);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wd_nogrant%0d", k), DW'({gnt1, gnt0}), 32'h0);
            chk($sformatf("wd_busy%0d", k), DW'(busy), 32'h1);
            if (k < 3) @(negedge clk);
        end
        chk("wd_done1", DW'({done1, done0}), 32'h2);
        chk("wd_rdata", rdata, 32'h0000_0097);
        @(negedge clk);
        chk("wd_next_gnt0", DW'({gnt1, gnt0}), 32'h1);
        repeat (4) @(negedge clk);
        chk("wd_done0", DW'({done1, done0}), 32'h1);
        chk("wd_rdata0", rdata, 32'h0000_0080);
        req0 = 1'b0;
        @(negedge clk);

        // async reset in the middle of a store
        req0 = 1'b1; we0 = 1'b1; addr0 = 9'h0AA; wdata0 = 32'h1234_5678;
        #1;
        chk("rs_gnt0", DW'({gnt1, gnt0}), 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("rs_stdat_strb", strb(), 32'h4);
        chk("rs_stdat_bus", bus_out, 32'h1234_5678);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rs_strb_cut", strb(), 32'h0);
        chk("rs_flags_cut", DW'({busy, gnt1, gnt0, done1, done0}), 32'h0);
        chk("rs_bus_cut", bus_out, 32'h0);
        chk("rs_rdata_cut", rdata, 32'h0);
        req0 = 1'b0; we0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 9'h010; addr1 = 9'h020;
        #1;
        chk("rs_first_gnt", DW'({gnt1, gnt0}), 32'h1);
        repeat (4) @(negedge clk);
        chk("rs_done0", DW'({done1, done0}), 32'h1);
        chk("rs_rdata", rdata, 32'hC0DE_0010);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        // random mixes: exclusivity, grant-to-done latency and load data
        for (int i = 0; i < 8; i++) shadow[i] = 32'hC0DE_0040 | DW'(i);
        for (int i = 0; i < 4; i++) ghist[i] = 2'b00;
        last_rd = 32'hC0DE_0010;
        pend0 = 1'b0; pend1 = 1'b0; done_cnt = 0; cyc = 0;
        while (done_cnt < 100 && cyc < 3000) begin
            chk("rnd_excl", DW'($countones({mar_en, mdr_en, mem_write}) <= 1), 32'h1);
            chk("rnd_latency", DW'({done1, done0}), DW'(ghist[3]));
            if (done0 || done1) begin
                done_cnt++;
                chk("rnd_rdata", rdata, last_rd);
            end
            if (done0) pend0 = 1'b0;
            if (done1) pend1 = 1'b0;
            if (!pend0 && $urandom_range(0, 1) == 1) begin
                pend0 = 1'b1; we0 = 1'($urandom_range(0, 1));
                addr0 = 9'h040 + AW'($urandom_range(0, 7)); wdata0 = $urandom;
            end
            if (!pend1 && $urandom_range(0, 1) == 1) begin
                pend1 = 1'b1; we1 = 1'($urandom_range(0, 1));
                addr1 = 9'h040 + AW'($urandom_range(0, 7)); wdata1 = $urandom;
            end
            req0 = pend0; req1 = pend1;
            #1;
            chk("rnd_gnt_onehot", DW'(!(gnt0 && gnt1)), 32'h1);
            if (gnt0) begin
                if (we0) shadow[addr0[2:0]] = wdata0; else last_rd = shadow[addr0[2:0]];
            end
            if (gnt1) begin
                if (we1) shadow[addr1[2:0]] = wdata1; else last_rd = shadow[addr1[2:0]];
            end
            ghist[3] = ghist[2]; ghist[2] = ghist[1]; ghist[1] = ghist[0]; ghist[0] = {gnt1, gnt0};
            @(negedge clk);
            cyc++;
        end
        chk("rnd_completed", DW'(done_cnt >= 100), 32'h1);
        req0 = 1'b0; req1 = 1'b0;
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_seq_arbiter.md
Name: mem_seq_arbiter

Overview:
- Sequences the MAR/MDR/memory datapath for complete load and store transactions, so the control unit no longer hand-drives MAR_rd, MDR_rd, Read and Write.
- Arbitrates two requesters for the single memory path: port 0 is the CPU control unit; port 1 is the program loader or debug port.
- Sits between the requesters and the bus/MAR/MDR/memory cluster, and drives the bus value plus all register enables.

Parameters:
- ADDR_W, 9, memory word-address width (512 words).
- DATA_W, 32, data word width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req0, req1  in  1 each  transaction request; held high until the matching done pulse.
- we0, we1  in  1 each  1 = store, 0 = load; sampled at grant.
- addr0, addr1  in  ADDR_W each  word address; sampled at grant.
- wdata0, wdata1  in  DATA_W each  store data; sampled at grant.
- gnt0, gnt1  out  1 each  one-cycle pulse when the port's request is accepted.
- done0, done1  out  1 each  one-cycle pulse when the transaction completes.
- rdata  out  DATA_W  load result; valid while doneN=1 and held afterwards.
- bus_out  out  DATA_W  value driven onto BusMuxOut.
- mar_en  out  1  MAR load enable.
- mdr_en  out  1  MDR load enable.
- mdr_from_mem  out  1  MDR source select (1 = memory Dataout, 0 = bus).
- mem_write  out  1  memory write strobe.
- mdr_q  in  DATA_W  MDR output, used to capture load data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, last_grant=1 (so port 0 wins the first tie). All outputs go to 0, including rdata, bus_out, gnt and done.
- State register: IDLE, ADDR, LD_MEM, LD_CAP, ST_DAT, ST_WR, DONE.
- IDLE:
  - If any req is high, grant one port. With a single requester, that port is granted. With both high, grant the port other than last_grant (round-robin).
  - At the grant edge: gntN pulses for one cycle; latch sel, we, addr and wdata; update last_grant; next state = ADDR.
- ADDR: bus_out=addr (zero-extended), mar_en=1. Next state = LD_MEM if we=0, else ST_DAT.
- LD_MEM: mdr_en=1, mdr_from_mem=1, bus_out=0. Next state = LD_CAP.
- LD_CAP: no enables. rdata<=mdr_q at the exit edge. Next state = DONE.
- ST_DAT: bus_out=wdata, mdr_en=1, mdr_from_mem=0. Next state = ST_WR.
- ST_WR: mem_write=1, other enables 0. Next state = DONE.
- DONE: done[sel]=1 for exactly this cycle. Next state = IDLE.
- Latency from the grant edge to the done pulse:
  - load: 4 cycles (ADDR, LD_MEM, LD_CAP, DONE);
  - store: 4 cycles (ADDR, ST_DAT, ST_WR, DONE).
- Back-to-back requests: a request still high in the IDLE cycle after DONE may be granted, so the minimum per-transaction period is 5 cycles.
- Enable and data outputs are registered (decoded from state). No two of mar_en, mdr_en, mem_write are ever high together.
- Requests are not sampled outside IDLE. A request dropping mid-transaction does not abort it; the transaction completes and done still pulses.
- addr, wdata and we changes after grant are ignored because they were latched.
- rdata is unchanged by store transactions.
- Reset mid-transaction: immediate return to IDLE with all strobes at 0. A mem_write in progress is cut; the memory content at that address is then unspecified, which the bench must tolerate.
- A requester asserting req in the same cycle its done pulses is treated as a new request in IDLE.

Decomposition:
- Shared package `mem_seq_pkg`:
  - state enum encoding;
  - ADDR_W/DATA_W defaults;
  - constant NUM_REQ=2.
- One natural sub-module, `rr_arb2`:
  - 2-way round-robin arbiter with last_grant register;
  - inputs req[1:0] and an advance strobe;
  - outputs a one-hot grant.
- FSM, latching and datapath strobes stay in the top module.

Test Plan:
- Single load:
  - stimulus: after reset, req0=1, we0=0, addr0=0x054, with memory preloaded 0x054=0x97;
  - response: gnt0 pulse; mar_en with bus_out=0x54 next cycle; then mdr_en+mdr_from_mem; done0 4 cycles after grant with rdata=0x97.
- Single store then load:
  - stimulus: req0 store addr0=0x034, wdata0=0x80 (memory initially 0x25), then a load from 0x034;
  - response: ST_DAT drives bus_out=0x80; mem_write exactly one cycle; the load returns rdata=0x80.
- Contention:
  - stimulus: req0 and req1 both held high, both loads (addr0=0x10, addr1=0x20) for 3 transactions;
  - response: grants alternate 0,1,0; done pulses match; rdata matches each port's address content.
- Request withdrawal:
  - stimulus: req1 dropped one cycle after gnt1; addr1 changed to 0x1FF after grant;
  - response: the transaction still completes on the original address; done1 pulses; no new grant while busy=1.
- Async reset mid-store:
  - stimulus: reset_n low during ST_DAT;
  - response: all strobes and busy go to 0 immediately without a clock edge; after release, first grant goes to port 0 under contention.
- Strobe exclusivity:
  - stimulus: 100 random load/store mixes on both ports;
  - response: assertion never fires on more than one of {mar_en, mdr_en, mem_write} high; every gnt is followed by exactly one done 4 cycles later.
